// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the controller state type for the
// block_ram responder.
package ahb_lite_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HSIZE encodings (anything above WORD is rejected)
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // HRESP encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Responder states: DATA is a zero-wait data phase, ERR1/ERR2 form the
   // two-cycle ERROR response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } bram_state_e;

   // A transfer is live when HTRANS is NONSEQ or SEQ.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite bus bundle between the matrix and the block_ram responder.
// HREADY is driven by the interconnect; it sits on the master side here.
interface ahb_bram_ctrl_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/bram_byte_merge.sv
// Combinational byte-lane merge: lanes with mask set take the new word,
// the rest keep the old word read from the RAM.
module bram_byte_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  mask,
   output logic [31:0] merged
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         // One 8-bit lane select per mask bit
         assign merged[gi*8 +: 8] = mask[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite responder in front of a 32-bit block_ram (registered read address,
// no byte enables). Sub-word writes are merged with the old word in the data
// phase, so every transfer completes with zero wait states. Misaligned or
// oversize transfers get a two-cycle ERROR and never write the RAM.
// Optional feature macro: BRAM_WPROT_EN -- writes to words below WPROT_WORDS
// are answered with ERROR (protects the preloaded code image).
module ahb_bram_ctrl
   import ahb_lite_pkg::*;
#(
   parameter int          MEMWIDTH    = 10,
   parameter int unsigned WPROT_WORDS = 64
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_bram_ctrl_if.slave      ahb,
   output logic [MEMWIDTH-3:0] ram_awrite,
   output logic [MEMWIDTH-3:0] ram_aread,
   output logic [31:0]         ram_din,
   output logic                ram_we,
   input  logic [31:0]         ram_dout
);

   localparam int AW = MEMWIDTH - 2;

   bram_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          write_q, write_d;
   logic [3:0]    mask_q, mask_d;
   logic          hreadyout_q, hreadyout_d;
   logic          hresp_q, hresp_d;

   logic [AW-1:0] haddr_word;
   logic          accept;
   logic          size_err;
   logic          prot_err;
   logic          xfer_err;
   logic [3:0]    lane_mask;

   // Address bits above the decoded window and HTRANS[0] carry no meaning here
   logic unused_bits;
   assign unused_bits = ^{ahb.HADDR[31:MEMWIDTH], ahb.HTRANS[0]};

   assign haddr_word = ahb.HADDR[MEMWIDTH-1:2];
   assign accept     = ahb.HSEL && ahb.HREADY && htrans_active(ahb.HTRANS);

   // Alignment / size legality of the address-phase request
   always_comb begin
      size_err = 1'b0;
      if (ahb.HSIZE > HSIZE_WORD)
         size_err = 1'b1;
      else if ((ahb.HSIZE == HSIZE_WORD) && (ahb.HADDR[1:0] != 2'b00))
         size_err = 1'b1;
      else if ((ahb.HSIZE == HSIZE_HALF) && ahb.HADDR[0])
         size_err = 1'b1;
   end

`ifdef BRAM_WPROT_EN
   // Writes into the protected low region are refused
   assign prot_err = ahb.HWRITE &&
                     ({{(32-AW){1'b0}}, haddr_word} < WPROT_WORDS);
`else
   logic unused_wprot;
   assign unused_wprot = (WPROT_WORDS == 32'd0);
   assign prot_err     = 1'b0;
`endif

   assign xfer_err = size_err || prot_err;

   // Byte lanes touched by the request
   always_comb begin
      lane_mask = 4'hF;
      case (ahb.HSIZE)
         HSIZE_BYTE: lane_mask = 4'b0001 << ahb.HADDR[1:0];
         HSIZE_HALF: lane_mask = 4'b0011 << {ahb.HADDR[1], 1'b0};
         default:    lane_mask = 4'hF;
      endcase
   end

   // Next-state, captured address-phase info and registered bus responses
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      mask_d  = mask_q;
      if (state_q == ST_ERR1) begin
         // Second ERROR cycle always follows; the bus is stalled meanwhile
         state_d = ST_ERR2;
         write_d = 1'b0;
      end else if (accept) begin
         state_d = xfer_err ? ST_ERR1 : ST_DATA;
         addr_d  = haddr_word;
         write_d = ahb.HWRITE && !xfer_err;
         mask_d  = xfer_err ? 4'h0 : lane_mask;
      end else begin
         state_d = ST_IDLE;
         write_d = 1'b0;
      end
      hreadyout_d = (state_d != ST_ERR1);
      hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   // State and response registers, cleared asynchronously
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         write_q     <= 1'b0;
         mask_q      <= 4'h0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         mask_q      <= mask_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // While the bus is stalled the RAM keeps reading the captured word, so the
   // old word for a merge is always at ram_dout during the data phase.
   assign ram_aread  = ahb.HREADY ? haddr_word : addr_q;
   assign ram_awrite = addr_q;
   assign ram_we     = (state_q == ST_DATA) && write_q;

   bram_byte_merge u_merge (
      .old_word (ram_dout),
      .new_word (ahb.HWDATA),
      .mask     (mask_q),
      .merged   (ram_din)
   );

   assign ahb.HRDATA    = ram_dout;
   assign ahb.HREADYOUT = hreadyout_q;
   assign ahb.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed scenarios then random pipelined traffic,
// checked against a word-array model of the memory built from the bus rules.
// Build with +define+BRAM_WPROT_EN to exercise write protection.
module tb_ahb_bram_ctrl;
   import ahb_lite_pkg::*;

   localparam int MW = 10;
   localparam int NW = 256;
`ifdef BRAM_WPROT_EN
   localparam logic [31:0] BASE = 32'h200;
   localparam int          WLO  = 56;
`else
   localparam logic [31:0] BASE = 32'h0;
   localparam int          WLO  = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb_bram_ctrl_if bus();
   logic [MW-3:0] ram_awrite, ram_aread;
   logic [31:0]   ram_din, ram_dout;
   logic          ram_we;

   // Single responder: the interconnect's HREADY is our HREADYOUT
   assign bus.HREADY = bus.HREADYOUT;

   ahb_bram_ctrl #(.MEMWIDTH(MW), .WPROT_WORDS(64)) dut (
      .HCLK       (clk),
      .HRESETn    (rst_n),
      .ahb        (bus),
      .ram_awrite (ram_awrite),
      .ram_aread  (ram_aread),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout)
   );

   // block_ram: registered read address, array written on the same edge
   logic [31:0]   bram [NW];
   logic [MW-3:0] read_a;
   always @(posedge clk) begin
      if (ram_we) bram[ram_awrite] <= ram_din;
      read_a <= ram_aread;
   end
   assign ram_dout = bram[read_a];

   // Reference model
   logic [31:0] ref_mem [NW];
   typedef struct {
      bit          valid;
      bit          wr;
      bit          err;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          has_lit;
      logic [31:0] lit;
   } xfer_t;
   xfer_t pend;

   int checks = 0;
   int failures = 0;
   int txn = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input bit wr, input logic [31:0] addr, input logic [2:0] size);
      int nbytes;
      if (size > 3'd2) return 1'b1;
      nbytes = 1 << size;
      if ((int'(addr[1:0]) % nbytes) != 0) return 1'b1;
`ifdef BRAM_WPROT_EN
      if (wr && (int'(addr[9:2]) < 64)) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] res;
      int lo, hi;
      res = old_w;
      lo = int'(addr[1:0]);
      hi = lo + (1 << size);
      for (int b = 0; b < 4; b++)
         if (b >= lo && b < hi) res[b*8 +: 8] = new_w[b*8 +: 8];
      return res;
   endfunction

   // Checks the data phase of the pending transfer (we are just past a negedge)
   task automatic check_pend();
      int w;
      logic [31:0] exp;
      w = int'(pend.addr[9:2]);
      txn++;
      if (!pend.valid) begin
         $display("txn %0d idle", txn);
         check("idle_ready", 32'(bus.HREADYOUT), 32'd1);
         check("idle_resp", 32'(bus.HRESP), 32'd0);
         check("idle_we", 32'(ram_we), 32'd0);
      end else if (pend.err) begin
         $display("txn %0d error wr=%0d addr=%h size=%0d", txn, pend.wr, pend.addr, pend.size);
         check("err1_ready", 32'(bus.HREADYOUT), 32'd0);
         check("err1_resp", 32'(bus.HRESP), 32'd1);
         check("err1_we", 32'(ram_we), 32'd0);
         bus.HSEL = 1'b0;
         bus.HTRANS = HTRANS_IDLE;
         @(posedge clk);
         @(negedge clk);
         #1;
         check("err2_ready", 32'(bus.HREADYOUT), 32'd1);
         check("err2_resp", 32'(bus.HRESP), 32'd1);
         check("err2_we", 32'(ram_we), 32'd0);
      end else if (pend.wr) begin
         exp = model_merge(ref_mem[w], pend.wdata, pend.addr, pend.size);
         $display("txn %0d write addr=%h size=%0d data=%h word=%h", txn, pend.addr, pend.size, pend.wdata, exp);
         check("wr_ready", 32'(bus.HREADYOUT), 32'd1);
         check("wr_resp", 32'(bus.HRESP), 32'd0);
         check("wr_we", 32'(ram_we), 32'd1);
         check("wr_awrite", 32'(ram_awrite), 32'(w));
         check("wr_din", ram_din, exp);
         ref_mem[w] = exp;
      end else begin
         $display("txn %0d read addr=%h size=%0d expect=%h", txn, pend.addr, pend.size, ref_mem[w]);
         check("rd_ready", 32'(bus.HREADYOUT), 32'd1);
         check("rd_resp", 32'(bus.HRESP), 32'd0);
         check("rd_we", 32'(ram_we), 32'd0);
         check("rd_data", bus.HRDATA, ref_mem[w]);
         if (pend.has_lit) check("rd_literal", bus.HRDATA, pend.lit);
      end
   endtask

   // One bus cycle: finish the pending data phase, issue a new address phase
   task automatic step(input bit sel, input logic [1:0] trans, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       input bit has_lit, input logic [31:0] lit);
      bus.HWDATA = (pend.valid && pend.wr) ? pend.wdata : $urandom;
      #1;
      check_pend();
      bus.HSEL   = sel;
      bus.HTRANS = trans;
      bus.HWRITE = wr;
      bus.HADDR  = addr;
      bus.HSIZE  = size;
      @(posedge clk);
      pend.valid   = sel && trans[1];
      pend.wr      = wr;
      pend.addr    = addr;
      pend.size    = size;
      pend.wdata   = wdata;
      pend.err     = model_err(wr, addr, size);
      pend.has_lit = has_lit;
      pend.lit     = lit;
      @(negedge clk);
   endtask

   task automatic wr_t(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      step(1'b1, HTRANS_NONSEQ, 1'b1, a, s, d, 1'b0, 32'h0);
   endtask
   task automatic rd_t(input logic [31:0] a, input logic [31:0] lit);
      step(1'b1, HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD, 32'h0, 1'b1, lit);
   endtask
   task automatic idle_t();
      step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         bram[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      pend = '{valid: 1'b0, wr: 1'b0, err: 1'b0, addr: 32'h0, size: 3'd0,
               wdata: 32'h0, has_lit: 1'b0, lit: 32'h0};
      bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
      bus.HADDR = 32'h0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", 32'(bus.HREADYOUT), 32'd1);
      check("rst_resp", 32'(bus.HRESP), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_awrite", 32'(ram_awrite), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_t();

      // Word write / read
      wr_t(BASE + 32'h10, HSIZE_WORD, 32'hDEADBEEF);
      rd_t(BASE + 32'h10, 32'hDEADBEEF);
      // Byte and halfword merges
      wr_t(BASE + 32'h10, HSIZE_WORD, 32'h11223344);
      wr_t(BASE + 32'h12, HSIZE_BYTE, 32'h00AA0000);
      rd_t(BASE + 32'h10, 32'h11AA3344);
      wr_t(BASE + 32'h10, HSIZE_HALF, 32'h0000BEEF);
      rd_t(BASE + 32'h10, 32'h11AABEEF);
      // Back-to-back same-word hazards
      wr_t(BASE + 32'h20, HSIZE_WORD, 32'hCAFEF00D);
      rd_t(BASE + 32'h20, 32'hCAFEF00D);
      wr_t(BASE + 32'h21, HSIZE_BYTE, 32'h00005500);
      rd_t(BASE + 32'h20, 32'hCAFE550D);
      // Misaligned word write: error, memory untouched
      wr_t(BASE + 32'h22, HSIZE_WORD, 32'h12345678);
      rd_t(BASE + 32'h20, 32'hCAFE550D);
      // Reset during a write data phase
      wr_t(BASE + 32'h30, HSIZE_WORD, 32'h12345678);
      idle_t();
      wr_t(BASE + 32'h30, HSIZE_WORD, 32'h99999999);
      bus.HWDATA = 32'h99999999;
      rst_n = 1'b0;
      #1;
      $display("txn %0d reset during write addr=%h", txn + 1, BASE + 32'h30);
      check("rstmid_we", 32'(ram_we), 32'd0);
      check("rstmid_ready", 32'(bus.HREADYOUT), 32'd1);
      check("rstmid_resp", 32'(bus.HRESP), 32'd0);
      bus.HSEL = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      pend.valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rd_t(BASE + 32'h30, 32'h12345678);
      idle_t();
`ifdef BRAM_WPROT_EN
      // Protection boundary
      wr_t(32'h0FC, HSIZE_WORD, 32'hFFFFFFFF);
      rd_t(32'h0FC, 32'h00000000);
      wr_t(32'h100, HSIZE_WORD, 32'h5A5A5A5A);
      rd_t(32'h100, 32'h5A5A5A5A);
`endif

      // Random pipelined traffic over a small window to provoke hazards
      for (int i = 0; i < 300; i++) begin
         bit          sel, wr;
         logic [1:0]  trans;
         logic [2:0]  size;
         logic [31:0] addr;
         int          w, lo;
         sel   = ($urandom_range(0, 7) != 0);
         trans = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) trans[1] = 1'b1;
         wr    = $urandom_range(0, 1) == 1;
         size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         w     = WLO + $urandom_range(0, 15);
         lo    = $urandom_range(0, 3);
         if (size <= 3'd2 && $urandom_range(0, 3) != 0) lo = lo - (lo % (1 << size));
         addr  = (32'($urandom_range(0, 15)) << 10) | 32'(w * 4 + lo);
         step(sel, trans, wr, addr, size, $urandom, 1'b0, 32'h0);
      end
      idle_t();
      idle_t();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
